// File: rtl/ro_puf_eval.sv
// Ring-oscillator PUF evaluator: enables a challenged oscillator pair, counts their
// synchronised rising edges over a programmable window and compares the two counts.
module ro_puf_eval #(
   parameter int unsigned N_RO   = 16,
   parameter int unsigned SEL_W  = 4,
   parameter int unsigned WIN_W  = 16,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned SETTLE = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N_RO-1:0]  ro_i,
   output logic [N_RO-1:0]  ro_en_o,
   input  logic             start_i,
   input  logic [SEL_W-1:0] sel_a_i,
   input  logic [SEL_W-1:0] sel_b_i,
   input  logic [WIN_W-1:0] win_len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             resp_o,
   output logic             tie_o,
   output logic             err_o,
   output logic [CNT_W-1:0] cnt_a_o,
   output logic [CNT_W-1:0] cnt_b_o
);

   localparam int unsigned SelN = 2 ** SEL_W;
   localparam int unsigned StlW = $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0] CntMax = '1;

   typedef enum logic [2:0] {StIdle, StSettle, StCount, StCompare, StDone} state_e;

   state_e            state_q, state_d;
   logic [N_RO-1:0]   sync1_q, sync2_q, sync3_q;
   logic [SEL_W-1:0]  sel_a_q, sel_a_d, sel_b_q, sel_b_d;
   logic [WIN_W-1:0]  win_q, win_d;
   logic [StlW-1:0]   stl_q, stl_d;
   logic [CNT_W-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
   logic [CNT_W-1:0]  out_a_q, out_a_d, out_b_q, out_b_d;
   logic [N_RO-1:0]   ro_en_q, ro_en_d;
   logic              busy_q, busy_d, resp_q, resp_d, tie_q, tie_d, err_q, err_d;
   logic [SelN-1:0]   edge_pad;
   logic [N_RO-1:0]   en_mask;
   logic              req_bad;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
         sel_a_q <= '0;
         sel_b_q <= '0;
         win_q   <= '0;
         stl_q   <= '0;
         cnt_a_q <= '0;
         cnt_b_q <= '0;
         out_a_q <= '0;
         out_b_q <= '0;
         ro_en_q <= '0;
         busy_q  <= 1'b0;
         resp_q  <= 1'b0;
         tie_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= ro_i;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
         win_q   <= win_d;
         stl_q   <= stl_d;
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
         out_a_q <= out_a_d;
         out_b_q <= out_b_d;
         ro_en_q <= ro_en_d;
         busy_q  <= busy_d;
         resp_q  <= resp_d;
         tie_q   <= tie_d;
         err_q   <= err_d;
      end
   end

   // Request decode straight from the inputs; only consulted in StIdle.
   always_comb begin
      en_mask = '0;
      for (int unsigned i = 0; i < N_RO; i++) begin
         en_mask[i] = (sel_a_i == SEL_W'(i)) || (sel_b_i == SEL_W'(i));
      end
      req_bad = (sel_a_i == sel_b_i) || (32'(sel_a_i) >= N_RO) || (32'(sel_b_i) >= N_RO) ||
                (win_len_i == '0);
   end

   always_comb begin
      state_d  = state_q;
      sel_a_d  = sel_a_q;
      sel_b_d  = sel_b_q;
      win_d    = win_q;
      stl_d    = stl_q;
      cnt_a_d  = cnt_a_q;
      cnt_b_d  = cnt_b_q;
      out_a_d  = out_a_q;
      out_b_d  = out_b_q;
      ro_en_d  = ro_en_q;
      busy_d   = busy_q;
      resp_d   = resp_q;
      tie_d    = tie_q;
      err_d    = err_q;
      edge_pad = '0;
      edge_pad[N_RO-1:0] = sync2_q & ~sync3_q;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               sel_a_d = sel_a_i;
               sel_b_d = sel_b_i;
               win_d   = win_len_i;
               if (req_bad) begin
                  err_d   = 1'b1;
                  resp_d  = 1'b0;
                  tie_d   = 1'b0;
                  out_a_d = '0;
                  out_b_d = '0;
                  state_d = StDone;
               end else begin
                  cnt_a_d = '0;
                  cnt_b_d = '0;
                  stl_d   = '0;
                  busy_d  = 1'b1;
                  ro_en_d = en_mask;
                  state_d = StSettle;
               end
            end
         end
         StSettle: begin
            if (stl_q == StlW'(SETTLE - 1)) state_d = StCount;
            else                            stl_d   = stl_q + StlW'(1);
         end
         StCount: begin
            if (edge_pad[sel_a_q] && (cnt_a_q != CntMax)) cnt_a_d = cnt_a_q + CNT_W'(1);
            if (edge_pad[sel_b_q] && (cnt_b_q != CntMax)) cnt_b_d = cnt_b_q + CNT_W'(1);
            if (win_q == WIN_W'(1)) state_d = StCompare;
            else                    win_d   = win_q - WIN_W'(1);
         end
         StCompare: begin
            resp_d  = cnt_a_q > cnt_b_q;
            tie_d   = cnt_a_q == cnt_b_q;
            out_a_d = cnt_a_q;
            out_b_d = cnt_b_q;
            err_d   = 1'b0;
            ro_en_d = '0;
            state_d = StDone;
         end
         StDone: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign ro_en_o = ro_en_q;
   assign busy_o  = busy_q;
   assign done_o  = (state_q == StDone);
   assign resp_o  = resp_q;
   assign tie_o   = tie_q;
   assign err_o   = err_q;
   assign cnt_a_o = out_a_q;
   assign cnt_b_o = out_b_q;

endmodule

// File: tb/tb_ro_puf_eval.sv
// Bench for ro_puf_eval: oscillator waveforms are recorded per clock and expected counts
// are derived from the recorded edges that fall inside each evaluation's counting window.
module tb_ro_puf_eval;

   localparam int unsigned N_RO = 16, SEL_W = 4, WIN_W = 16, SETTLE = 4, HMAX = 16384;

   logic              clk = 1'b0;
   logic              rst, start;
   logic [N_RO-1:0]   ro = '0;
   logic [SEL_W-1:0]  sel_a, sel_b;
   logic [WIN_W-1:0]  win;
   logic [N_RO-1:0]   ro_en, ro_en_s;
   logic              busy, done, resp, tie, err;
   logic              busy_s, done_s, resp_s, tie_s, err_s;
   logic [15:0]       cnt_a, cnt_b;
   logic [3:0]        cnt_a_s, cnt_b_s;

   int unsigned n_pass = 0, n_chk = 0, n_fail = 0;
   int unsigned per [N_RO];
   int unsigned ph  [N_RO];
   logic [N_RO-1:0] hist [HMAX];
   int unsigned cyc = 0;

   ro_puf_eval #(.N_RO(N_RO), .SEL_W(SEL_W), .WIN_W(WIN_W), .CNT_W(16), .SETTLE(SETTLE)) dut (
      .clk_i(clk), .rst_i(rst), .ro_i(ro), .ro_en_o(ro_en), .start_i(start),
      .sel_a_i(sel_a), .sel_b_i(sel_b), .win_len_i(win), .busy_o(busy), .done_o(done),
      .resp_o(resp), .tie_o(tie), .err_o(err), .cnt_a_o(cnt_a), .cnt_b_o(cnt_b)
   );

   ro_puf_eval #(.N_RO(N_RO), .SEL_W(SEL_W), .WIN_W(WIN_W), .CNT_W(4), .SETTLE(SETTLE)) dut_s (
      .clk_i(clk), .rst_i(rst), .ro_i(ro), .ro_en_o(ro_en_s), .start_i(start),
      .sel_a_i(sel_a), .sel_b_i(sel_b), .win_len_i(win), .busy_o(busy_s), .done_o(done_s),
      .resp_o(resp_s), .tie_o(tie_s), .err_o(err_s), .cnt_a_o(cnt_a_s), .cnt_b_o(cnt_b_s)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cyc < HMAX) hist[cyc] <= ro;
      cyc <= cyc + 1;
   end

   // Oscillators change on the falling edge so every rising-edge sample is stable.
   always @(negedge clk) begin
      for (int i = 0; i < N_RO; i++) begin
         if (per[i] == 0) ro[i] = 1'b0;
         else begin
            ph[i] = (ph[i] + 1) % per[i];
            ro[i] = (ph[i] < per[i] / 2);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Rising edges sampled at clock k-1 -> k, for the samples that land in the window.
   function automatic int unsigned model_cnt(int unsigned idx, int unsigned t, int unsigned w);
      int unsigned c = 0;
      for (int unsigned k = t + SETTLE - 1; k <= t + SETTLE + w - 2; k++) begin
         if (k < HMAX && !hist[k-1][idx] && hist[k][idx]) c++;
      end
      return c;
   endfunction

   function automatic int unsigned sat(int unsigned v, int unsigned mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic run_valid(input int unsigned a, input int unsigned b, input int unsigned w,
                            input bit poke);
      int unsigned t, n, ea, eb, sa, sb, dones;
      logic [N_RO-1:0] mask;
      bit en_bad;
      mask = '0;
      mask[a] = 1'b1;
      mask[b] = 1'b1;
      @(negedge clk);
      start = 1'b1; sel_a = SEL_W'(a); sel_b = SEL_W'(b); win = WIN_W'(w); t = cyc;
      @(negedge clk);
      start = 1'b0;
      check("busy_rise", busy, 1);
      check("ro_en_rise", ro_en, mask);
      n = 0;
      en_bad = 1'b0;
      while (!done && n < SETTLE + w + 20) begin
         en_bad |= (ro_en !== mask) || (busy !== 1'b1) || (ro_en_s !== mask);
         start = poke && (cyc == t + SETTLE + w / 2 + 1);
         if (start) begin
            sel_a = SEL_W'((a + 1) % N_RO);
            sel_b = SEL_W'((b + 3) % N_RO);
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check("done_time", cyc, t + SETTLE + w + 2);
      check("en_hold", en_bad, 0);
      ea = sat(model_cnt(a, t, w), 65535);
      eb = sat(model_cnt(b, t, w), 65535);
      sa = sat(ea, 15);
      sb = sat(eb, 15);
      check("cnt_a", cnt_a, ea);
      check("cnt_b", cnt_b, eb);
      check("resp", resp, ea > eb);
      check("tie", tie, ea == eb);
      check("err", err, 0);
      check("ro_en_drop", ro_en, 0);
      check("busy_in_done", busy, 1);
      check("small_done", done_s, 1);
      check("small_cnt_a", cnt_a_s, sa);
      check("small_cnt_b", cnt_b_s, sb);
      check("small_resp", resp_s, sa > sb);
      check("small_tie", tie_s, sa == sb);
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 0) check("busy_drop", busy, 0);
         if (done || done_s) dones++;
      end
      check("single_done", dones, 0);
   endtask

   task automatic run_invalid(input int unsigned a, input int unsigned b, input int unsigned w);
      @(negedge clk);
      start = 1'b1; sel_a = SEL_W'(a); sel_b = SEL_W'(b); win = WIN_W'(w);
      @(negedge clk);
      start = 1'b0;
      check("inv_done", done, 1);
      check("inv_err", err, 1);
      check("inv_busy", busy, 0);
      check("inv_ro_en", ro_en, 0);
      check("inv_cnt_a", cnt_a, 0);
      check("inv_cnt_b", cnt_b, 0);
      check("inv_resp", resp, 0);
      check("inv_tie", tie, 0);
      check("inv_small_err", err_s, 1);
      @(negedge clk);
      check("inv_done_drop", done, 0);
      check("inv_ro_en_after", ro_en, 0);
   endtask

   task automatic reset_abort(input int unsigned a, input int unsigned b, input int unsigned w);
      int unsigned t, n, dones;
      @(negedge clk);
      start = 1'b1; sel_a = SEL_W'(a); sel_b = SEL_W'(b); win = WIN_W'(w); t = cyc;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (cyc < t + SETTLE + w / 2 && n < SETTLE + w) begin
         @(negedge clk);
         n++;
      end
      check("abort_mid_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_ro_en", ro_en, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_resp", resp, 0);
      check("abort_tie", tie, 0);
      check("abort_err", err, 0);
      check("abort_cnt_a", cnt_a, 0);
      check("abort_cnt_b", cnt_b, 0);
      dones = 0;
      for (int i = 0; i < w + 20; i++) begin
         @(negedge clk);
         if (done || busy || ro_en != '0) dones++;
      end
      check("abort_quiet", dones, 0);
   endtask

   initial begin
      int unsigned a, b, w;
      rst = 1'b1; start = 1'b0; sel_a = '0; sel_b = '0; win = '0;
      for (int i = 0; i < N_RO; i++) begin
         per[i] = 0;
         ph[i]  = $urandom_range(0, 19);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_ro_en", ro_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_resp", resp, 0);
      check("rst_err", err, 0);
      check("rst_cnt_a", cnt_a, 0);

      per[3] = 6; per[7] = 8;
      repeat (4) @(negedge clk);
      run_valid(3, 7, 240, 1'b0);
      check("tp_fast_a", cnt_a, 40);
      check("tp_fast_b", cnt_b, 30);
      check("tp_fast_resp", resp, 1);
      run_valid(7, 3, 240, 1'b0);
      check("tp_swap_a", cnt_a, 30);
      check("tp_swap_resp", resp, 0);

      per[0] = 10; per[15] = 10;
      run_valid(0, 15, 100, 1'b0);
      check("tp_tie_a", cnt_a, 10);
      check("tp_tie", tie, 1);

      run_invalid(5, 5, 100);
      run_valid(3, 7, 50, 1'b0);
      run_invalid(2, 9, 0);
      run_valid(3, 7, 60, 1'b0);

      per[1] = 4; per[2] = 5;
      run_valid(1, 2, 200, 1'b1);
      check("tp_sat_big", cnt_a, 50);
      check("tp_sat_small", cnt_a_s, 15);

      reset_abort(3, 7, 240);
      run_valid(3, 7, 240, 1'b0);
      check("tp_after_abort_a", cnt_a, 40);

      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < N_RO; i++) per[i] = $urandom_range(3, 20);
         a = $urandom_range(0, N_RO - 1);
         b = $urandom_range(0, N_RO - 1);
         w = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 300);
         if (a == b || w == 0) run_invalid(a, b, w);
         else run_valid(a, b, w, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
